// File: rtl/prod_pkg.sv
// Shared types and default constants for the burst/gap beat producer.
package prod_pkg;
  typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

  typedef struct packed {
    logic clr;
    logic inc;
  } cnt_ctl_t;

  localparam int DEF_DW          = 8;
  localparam int DEF_START       = 1;
  localparam int DEF_BURST_LEN   = 4;
  localparam int DEF_GAP_LEN     = 2;
  localparam int DEF_TOTAL_BEATS = 16;
endpackage

// File: rtl/prod_cnt.sv
// Generic up-counter with synchronous clear and parallel load.
module prod_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_b)   q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= ld_val;
    else if (inc) q <= q + W'(1);
  end
endmodule

// File: rtl/prod.sv
// Free-running producer: bursts of BURST_LEN beats separated by GAP_LEN idle
// cycles, stopping after TOTAL_BEATS beats (0 = forever).
import prod_pkg::*;

module prod #(
  parameter int            DW          = DEF_DW,
  parameter logic [DW-1:0] START       = DW'(DEF_START),
  parameter int            BURST_LEN   = DEF_BURST_LEN,
  parameter int            GAP_LEN     = DEF_GAP_LEN,
  parameter int            TOTAL_BEATS = DEF_TOTAL_BEATS
) (
  input  logic          clk,
  input  logic          rst_b,
  output logic          val,
  output logic [DW-1:0] data
);
  localparam logic [7:0]  BL_M1     = 8'(BURST_LEN - 1);
  localparam logic [7:0]  GL_M1     = 8'(GAP_LEN - 1);
  localparam logic [15:0] TB_M1     = 16'(TOTAL_BEATS - 1);
  localparam bit          HAS_GAP   = (GAP_LEN > 0);
  localparam bit          HAS_TOTAL = (TOTAL_BEATS > 0);

  state_t        state, state_d;
  logic          val_d;
  logic [DW-1:0] data_d;
  cnt_ctl_t      bctl, gctl, tctl;
  logic [7:0]    bcnt, gcnt;
  logic [15:0]   tcnt;
  logic          burst_last, gap_last, total_last;

  prod_cnt #(.W(8))  u_bcnt (.clk(clk), .rst_b(rst_b), .clr(bctl.clr), .ld(1'b0),
                             .ld_val('0), .inc(bctl.inc), .q(bcnt));
  prod_cnt #(.W(8))  u_gcnt (.clk(clk), .rst_b(rst_b), .clr(gctl.clr), .ld(1'b0),
                             .ld_val('0), .inc(gctl.inc), .q(gcnt));
  prod_cnt #(.W(16)) u_tcnt (.clk(clk), .rst_b(rst_b), .clr(tctl.clr), .ld(1'b0),
                             .ld_val('0), .inc(tctl.inc), .q(tcnt));

  assign burst_last = (bcnt == BL_M1);
  assign gap_last   = (gcnt == GL_M1);
  assign total_last = HAS_TOTAL && (tcnt == TB_M1);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      val   <= 1'b0;
      data  <= START;
    end else begin
      state <= state_d;
      val   <= val_d;
      data  <= data_d;
    end
  end

  always_comb begin
    state_d = state;
    val_d   = 1'b0;
    data_d  = data;
    bctl    = '0;
    gctl    = '0;
    tctl    = '0;
    case (state)
      IDLE: begin
        state_d = BURST;
        val_d   = 1'b1;
      end
      BURST: begin
        // every BURST cycle is a beat: advance payload and counters
        data_d   = data + DW'(1);
        tctl.inc = 1'b1;
        bctl.inc = 1'b1;
        val_d    = 1'b1;
        if (total_last) begin
          state_d = DONE;
          val_d   = 1'b0;
        end else if (burst_last) begin
          bctl.inc = 1'b0;
          bctl.clr = 1'b1;
          if (HAS_GAP) begin
            state_d  = GAP;
            val_d    = 1'b0;
            gctl.clr = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d  = BURST;
          val_d    = 1'b1;
          gctl.clr = 1'b1;
        end else begin
          gctl.inc = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_prod.sv
// Randomized-reset check of three producer configurations against a
// closed-form model of the beat schedule.
module tb_prod;
  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       val0, val1, val2;
  logic [7:0] data0, data1, data2;
  int         total = 0;
  int         bad = 0;
  int         n = 0;
  int         sum;

  always #5 clk = ~clk;

  prod u0 (.clk(clk), .rst_b(rst_b), .val(val0), .data(data0));
  prod #(.DW(8), .START(8'hFE), .BURST_LEN(4), .GAP_LEN(0), .TOTAL_BEATS(0))
    u1 (.clk(clk), .rst_b(rst_b), .val(val1), .data(data1));
  prod #(.DW(8), .START(8'd1), .BURST_LEN(3), .GAP_LEN(1), .TOTAL_BEATS(6))
    u2 (.clk(clk), .rst_b(rst_b), .val(val2), .data(data2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // n = edges with rst_b high since the last reset edge; beats follow a
  // periodic schedule of bl beats then gl idle cycles, truncated at tb beats.
  function automatic void model(input int bl, input int gl, input int tb, input int start,
                                output logic v, output logic [31:0] d);
    int per, q, p, bb, c;
    if (n == 0) begin
      v = 1'b0;
      d = 32'(start);
      return;
    end
    per = bl + gl;
    q   = (n - 1) / per;
    p   = (n - 1) % per;
    bb  = q * bl + ((p < bl) ? p : bl);
    v   = (p < bl) && (tb == 0 || bb < tb);
    c   = (tb > 0 && bb > tb) ? tb : bb;
    d   = 32'((start + c) & 8'hFF);
  endfunction

  task automatic step(input logic r);
    logic        v;
    logic [31:0] d;
    rst_b = r;
    @(posedge clk);
    n = r ? n + 1 : 0;
    @(negedge clk);
    model(4, 2, 16, 1, v, d);
    chk("u0.val", 32'(val0), 32'(v));
    chk("u0.data", 32'(data0), d);
    model(4, 0, 0, 'hFE, v, d);
    chk("u1.val", 32'(val1), 32'(v));
    chk("u1.data", 32'(data1), d);
    model(3, 1, 6, 1, v, d);
    chk("u2.val", 32'(val2), 32'(v));
    chk("u2.data", 32'(data2), d);
  endtask

  initial begin
    @(negedge clk);
    step(1'b0);
    step(1'b0);
    // full default sequence with a sink summing accepted beats
    sum = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      if (val0) sum += int'(data0);
    end
    chk("sink.sum", 32'(sum), 32'd136);
    chk("done.data", 32'(data0), 32'd17);
    chk("done.val", 32'(val0), 32'd0);
    // reset while DONE, then a one-edge reset pulse inside the second burst
    step(1'b0);
    for (int i = 0; i < 8; i++) step(1'b1);
    step(1'b0);
    chk("pulse.data", 32'(data0), 32'd1);
    for (int i = 0; i < 30; i++) step(1'b1);
    // random reset pulses over long runs (wrap-around on u1)
    for (int i = 0; i < 1500; i++) step(($urandom_range(59) == 0) ? 1'b0 : 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
